// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the BRAM read arbiter.
//   arb_state_e : arbiter FSM states
//   DEF_*       : default parameter values
//   CNT_W       : width of the optional performance counters
//   sat_inc()   : saturating increment for the performance counters
package rd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StWait,
    StResp
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_BRAM_LAT = 2;

  localparam int unsigned CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req_i     : request vector
//   ptr_i     : highest-priority index; search runs upward from here, wrapping
//   gnt_idx_o : index of the first set request found (0 when none)
//   any_req_o : at least one request is set
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       any_req_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    int   j;
    logic found;
    j         = 0;
    found     = 1'b0;
    gnt_idx_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      j = (int'(ptr_i) + i) % int'(NUM_REQ);
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_idx_o = IdxW'(j);
      end
    end
    any_req_o = found;
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one pipelined BRAM read port between NUM_REQ AXI-style read requesters.
// One transaction in flight; requesters are granted round-robin.
//   clk, aresetn      : clock, synchronous active-low reset
//   s_arvalid_i/_o... : per-requester AR handshake (s_araddr_i packed, ADDR_W per requester)
//   s_rvalid_o, s_rready_i, s_rdata_o : per-requester R handshake, shared data bus
//   bram_en_o, bram_addr_o, bram_rdata_i : BRAM read port, BRAM_LAT cycles en->data
// Optional macro RD_ARB_PERF_CNT_EN adds grant_cnt_o (per-requester AR handshakes)
// and stall_cnt_o (cycles the granted requester withholds rready), both saturating.
module bram_read_arbiter
  import rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BRAM_LAT = DEF_BRAM_LAT
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        s_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr_i,
  output logic [NUM_REQ-1:0]        s_arready_o,
  output logic [NUM_REQ-1:0]        s_rvalid_o,
  input  logic [NUM_REQ-1:0]        s_rready_i,
  output logic [DATA_W-1:0]         s_rdata_o,
  output logic                      bram_en_o,
  output logic [ADDR_W-1:0]         bram_addr_o,
  input  logic [DATA_W-1:0]         bram_rdata_i
`ifdef RD_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  grant_cnt_o,
  output logic [CNT_W-1:0]          stall_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned LatW = $clog2(BRAM_LAT + 1);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [NUM_REQ-1:0]  arready_q, arready_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                bram_en_q, bram_en_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;

  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i     (s_arvalid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (pick_idx),
    .any_req_o (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    bram_en_d   = 1'b0;
    bram_addr_d = bram_addr_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          arready_d = OneHot0 << pick_idx;
          state_d   = StAccept;
        end
      end
      StAccept: begin
        arready_d = '0;
        if (s_arvalid_i[gnt_idx_q]) begin
          bram_addr_d = s_araddr_i[int'(gnt_idx_q)*ADDR_W +: ADDR_W];
          bram_en_d   = 1'b1;
          lat_cnt_d   = LatW'(BRAM_LAT);
          state_d     = StWait;
        end else begin
          // Requester withdrew arvalid: drop the grant without advancing rr_ptr.
          state_d = StIdle;
        end
      end
      StWait: begin
        if (lat_cnt_q == '0) begin
          rdata_d  = bram_rdata_i;
          rvalid_d = OneHot0 << gnt_idx_q;
          state_d  = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - LatW'(1);
        end
      end
      StResp: begin
        if (s_rready_i[gnt_idx_q]) begin
          rvalid_d = '0;
          rr_ptr_d = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      lat_cnt_q   <= '0;
      arready_q   <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
    end
  end

  assign s_arready_o = arready_q;
  assign s_rvalid_o  = rvalid_q;
  assign s_rdata_o   = rdata_q;
  assign bram_en_o   = bram_en_q;
  assign bram_addr_o = bram_addr_q;

`ifdef RD_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // arready is always high in StAccept, so arvalid alone completes the handshake.
    if (state_q == StAccept && s_arvalid_i[gnt_idx_q]) begin
      grant_cnt_d[gnt_idx_q] = sat_inc(grant_cnt_q[gnt_idx_q]);
    end
    if (state_q == StResp && !s_rready_i[gnt_idx_q]) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed self-checking bench for bram_read_arbiter (default parameters).
// A two-stage BRAM model (BRAM_LAT=2) backs the arbiter; every expected value is
// written out here by hand or taken from the bench's own memory image.
module tb_bram_read_arbiter;
  import rd_arb_pkg::*;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BRAM_LAT = 2;

  logic                      clk;
  logic                      aresetn;
  logic [NUM_REQ-1:0]        s_arvalid;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ-1:0]        s_arready;
  logic [NUM_REQ-1:0]        s_rvalid;
  logic [NUM_REQ-1:0]        s_rready;
  logic [DATA_W-1:0]         s_rdata;
  logic                      bram_en;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_rdata;
`ifdef RD_ARB_PERF_CNT_EN
  logic [NUM_REQ*CNT_W-1:0]  grant_cnt;
  logic [CNT_W-1:0]          stall_cnt;
`endif

  int checks;
  int errors;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] pipe1;

  bram_read_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BRAM_LAT (BRAM_LAT)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .s_arvalid_i  (s_arvalid),
    .s_araddr_i   (s_araddr),
    .s_arready_o  (s_arready),
    .s_rvalid_o   (s_rvalid),
    .s_rready_i   (s_rready),
    .s_rdata_o    (s_rdata),
    .bram_en_o    (bram_en),
    .bram_addr_o  (bram_addr),
    .bram_rdata_i (bram_rdata)
`ifdef RD_ARB_PERF_CNT_EN
    ,
    .grant_cnt_o  (grant_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: data appears two cycles after the enable pulse.
  always_ff @(posedge clk) begin
    if (bram_en) pipe1 <= mem[bram_addr];
    bram_rdata <= pipe1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int r, input logic [ADDR_W-1:0] a);
    s_araddr[r*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // Full transaction from IDLE for requester r; rready withheld for 'stall' cycles.
  task automatic read_txn(input int r, input logic [ADDR_W-1:0] a, input int stall);
    logic [NUM_REQ-1:0] oh;
    oh        = NUM_REQ'(1) << r;
    s_arvalid = oh;
    set_addr(r, a);
    s_rready  = (stall > 0) ? ~oh : '1;
    tick();
    chk("txn_arready", 64'(s_arready), 64'(oh));
    chk("txn_en_early", 64'(bram_en), 64'd0);
    tick();
    s_arvalid = '0;
    chk("txn_bram_en", 64'(bram_en), 64'd1);
    chk("txn_bram_addr", 64'(bram_addr), 64'(a));
    chk("txn_arready_drop", 64'(s_arready), 64'd0);
    tick();
    chk("txn_en_pulse", 64'(bram_en), 64'd0);
    tick();
    chk("txn_rvalid_early", 64'(s_rvalid), 64'd0);
    tick();
    chk("txn_rvalid", 64'(s_rvalid), 64'(oh));
    chk("txn_rdata", 64'(s_rdata), 64'(mem[a]));
    repeat (stall) begin
      tick();
      chk("txn_rvalid_hold", 64'(s_rvalid), 64'(oh));
    end
    s_rready = '1;
    tick();
    chk("txn_rvalid_clear", 64'(s_rvalid), 64'd0);
  endtask

  logic [NUM_REQ-1:0] exp_v;
  logic [ADDR_W-1:0]  exp_a;

  initial begin
    checks    = 0;
    errors    = 0;
    aresetn   = 1'b0;
    s_arvalid = '0;
    s_araddr  = '0;
    s_rready  = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'hC0DE_0000 | a;
    mem[5] = 32'hDEAD_BEEF;

    // Reset state
    tick();
    tick();
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rdata", 64'(s_rdata), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    aresetn = 1'b1;

    // Single read: requester 1, address 5, rvalid at cycle 5
    read_txn(1, 10'h005, 0);

    // Four requesters held: grants 0,1,2,3,0 every 6 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, ADDR_W'(10'h020 + i));
    s_arvalid = '1;
    s_rready  = '1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp_v = (c % 6 == 1) ? (NUM_REQ'(1) << ((c / 6) % 4)) : '0;
      chk("rr_arready", 64'(s_arready), 64'(exp_v));
      exp_v = (c % 6 == 5) ? (NUM_REQ'(1) << ((c / 6) % 4)) : '0;
      chk("rr_rvalid", 64'(s_rvalid), 64'(exp_v));
      if (c % 6 == 5) begin
        exp_a = ADDR_W'(10'h020 + (c / 6) % 4);
        chk("rr_rdata", 64'(s_rdata), 64'(mem[exp_a]));
      end
      if (c == 30) s_arvalid = '0;
    end

    // Requester 2 stalls rready for 10 cycles while requester 0 waits (rr_ptr=1)
    s_arvalid = 4'b0100;
    set_addr(2, 10'h042);
    s_rready  = '0;
    tick();
    chk("stall_arready", 64'(s_arready), 64'h4);
    tick();
    chk("stall_bram_en", 64'(bram_en), 64'd1);
    s_arvalid = 4'b0001;
    set_addr(0, 10'h040);
    s_rready  = 4'b1011;
    tick();
    tick();
    for (int c = 5; c <= 14; c++) begin
      tick();
      chk("stall_rvalid", 64'(s_rvalid), 64'h4);
      chk("stall_rdata", 64'(s_rdata), 64'(mem[10'h042]));
      chk("stall_no_arready", 64'(s_arready), 64'd0);
    end
    tick();
    chk("stall_rvalid_last", 64'(s_rvalid), 64'h4);
    s_rready = '1;
    tick();
    chk("stall_rvalid_clear", 64'(s_rvalid), 64'd0);
    chk("stall_idle_no_arready", 64'(s_arready), 64'd0);
    tick();
    chk("stall_next_grant", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = '0;
    chk("stall_next_addr", 64'(bram_addr), 64'h040);
    tick();
    tick();
    tick();
    chk("stall_next_rvalid", 64'(s_rvalid), 64'h1);
    chk("stall_next_rdata", 64'(s_rdata), 64'(mem[10'h040]));
    tick();

    // Requester 3 drops arvalid in ACCEPT; rr_ptr stays 1 so 3 beats 0 next time
    s_arvalid = 4'b1000;
    set_addr(3, 10'h033);
    tick();
    chk("abort_arready", 64'(s_arready), 64'h8);
    s_arvalid = '0;
    tick();
    chk("abort_no_bram_en", 64'(bram_en), 64'd0);
    chk("abort_arready_drop", 64'(s_arready), 64'd0);
    s_arvalid = 4'b1001;
    set_addr(0, 10'h030);
    tick();
    chk("abort_regrant", 64'(s_arready), 64'h8);
    tick();
    s_arvalid = 4'b0001;
    chk("abort_regrant_en", 64'(bram_en), 64'd1);
    chk("abort_regrant_addr", 64'(bram_addr), 64'h033);
    tick();
    tick();
    tick();
    chk("abort_rvalid", 64'(s_rvalid), 64'h8);
    chk("abort_rdata", 64'(s_rdata), 64'(mem[10'h033]));
    tick();
    tick();
    chk("after3_grant0", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = '0;
    tick();
    tick();
    tick();
    chk("after3_rvalid0", 64'(s_rvalid), 64'h1);
    tick();

    // Reset during WAIT (rr_ptr=1 beforehand); afterwards 0 wins over 2
    s_arvalid = 4'b0010;
    set_addr(1, 10'h031);
    tick();
    chk("rstw_arready", 64'(s_arready), 64'h2);
    tick();
    s_arvalid = '0;
    tick();
    aresetn = 1'b0;
    tick();
    chk("rstw_rvalid", 64'(s_rvalid), 64'd0);
    chk("rstw_arready0", 64'(s_arready), 64'd0);
    chk("rstw_bram_en", 64'(bram_en), 64'd0);
    chk("rstw_bram_addr", 64'(bram_addr), 64'd0);
    chk("rstw_rdata", 64'(s_rdata), 64'd0);
    aresetn = 1'b1;
    repeat (4) begin
      tick();
      chk("rstw_quiet_rvalid", 64'(s_rvalid), 64'd0);
      chk("rstw_quiet_en", 64'(bram_en), 64'd0);
    end
    s_arvalid = 4'b0101;
    set_addr(0, 10'h050);
    set_addr(2, 10'h052);
    tick();
    chk("rstw_first_grant", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = '0;
    chk("rstw_first_addr", 64'(bram_addr), 64'h050);
    tick();
    tick();
    tick();
    chk("rstw_first_rvalid", 64'(s_rvalid), 64'h1);
    chk("rstw_first_rdata", 64'(s_rdata), 64'(mem[10'h050]));
    tick();

`ifdef RD_ARB_PERF_CNT_EN
    do_reset();
    chk("perf_rst_grant", 64'(grant_cnt), 64'd0);
    read_txn(0, 10'h010, 0);
    read_txn(0, 10'h011, 2);
    read_txn(0, 10'h012, 0);
    chk("perf_grant0", 64'(grant_cnt[15:0]), 64'd3);
    chk("perf_grant_other", 64'(grant_cnt[NUM_REQ*CNT_W-1:16]), 64'd0);
    chk("perf_stall", 64'(stall_cnt), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
